// File: rtl/regfile_mp.sv
// Multi-ported integer register file with write-to-read bypass,
// per-register pending-write scoreboard and post-reset zero scrub.
//
// Ports:
//   clock, reset            rising-edge clock, sync active-high reset
//   ready                   scrub finished, file usable
//   readAddress/readData    packed combinational read ports
//   readBusy                per read port: operand still pending
//   writeEnable/Address/Data packed write ports (high index wins)
//   reserveEnable/Address   issue claims a destination register
//   flush                   clear every pending bit
//   debug_regs_flat         flattened register contents
module regfile_mp #(
    parameter int XLEN        = 32,
    parameter int NUM_REGS    = 32,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 1,
    parameter bit ZERO_REG    = 1'b1,
    localparam int AW         = $clog2(NUM_REGS)
) (
    input  logic                          clock,
    input  logic                          reset,
    output logic                          ready,
    input  logic [READ_PORTS*AW-1:0]      readAddress,
    output logic [READ_PORTS*XLEN-1:0]    readData,
    output logic [READ_PORTS-1:0]         readBusy,
    input  logic [WRITE_PORTS-1:0]        writeEnable,
    input  logic [WRITE_PORTS*AW-1:0]     writeAddress,
    input  logic [WRITE_PORTS*XLEN-1:0]   writeData,
    input  logic                          reserveEnable,
    input  logic [AW-1:0]                 reserveAddress,
    input  logic                          flush,
    output logic [NUM_REGS*XLEN-1:0]      debug_regs_flat
);

    typedef enum logic {
        SCRUB = 1'b0,
        READY = 1'b1
    } state_t;

    state_t          state;
    state_t          stateNext;
    logic [AW-1:0]   scrubIndex;
    logic [XLEN-1:0] registers [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic            active;

    logic [WRITE_PORTS-1:0] wvalid;
    logic [AW-1:0]          waddr [WRITE_PORTS];
    logic [XLEN-1:0]        wdata [WRITE_PORTS];

    logic reserveValid;

    assign active = (state == READY);
    assign ready  = active;

    // Writes only count once the file is live; r0 drops them
    // when it is hardwired.
    always_comb begin
        wvalid = '0;
        for (int w = 0; w < WRITE_PORTS; w++) begin
            waddr[w]  = writeAddress[w*AW +: AW];
            wdata[w]  = writeData[w*XLEN +: XLEN];
            wvalid[w] = writeEnable[w] && active &&
                        !(ZERO_REG && waddr[w] == '0);
        end
    end

    assign reserveValid = reserveEnable && active &&
                          !(ZERO_REG && reserveAddress == '0);

    always_comb begin
        stateNext = state;
        unique case (state)
            SCRUB: begin
                if (scrubIndex == AW'(NUM_REGS - 1))
                    stateNext = READY;
            end
            READY: stateNext = READY;
            default: stateNext = SCRUB;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= SCRUB;
            scrubIndex <= '0;
        end else begin
            state <= stateNext;
            // Wraps to 0 on the final scrub edge.
            if (state == SCRUB)
                scrubIndex <= scrubIndex + AW'(1);
        end
    end

    // Storage has no reset; the scrub zeroes it instead.
    // Ascending port loop lets the highest port's NBA land last.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == SCRUB)
                registers[scrubIndex] <= '0;
            for (int w = 0; w < WRITE_PORTS; w++) begin
                if (wvalid[w])
                    registers[waddr[w]] <= wdata[w];
            end
        end
    end

    // Ordering matters: flush, then write clears, then the
    // reservation, which is the newest producer and wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy <= '0;
        end else if (active) begin
            if (flush)
                busy <= '0;
            for (int w = 0; w < WRITE_PORTS; w++) begin
                if (wvalid[w])
                    busy[waddr[w]] <= 1'b0;
            end
            if (reserveValid)
                busy[reserveAddress] <= 1'b1;
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
        logic [AW-1:0]   addr;
        logic            hit;
        logic [XLEN-1:0] fwd;
        logic            zero;

        assign addr = readAddress[p*AW +: AW];

        always_comb begin
            hit = 1'b0;
            fwd = '0;
            for (int w = 0; w < WRITE_PORTS; w++) begin
                if (wvalid[w] && waddr[w] == addr) begin
                    hit = 1'b1;
                    fwd = wdata[w];
                end
            end
        end

        assign zero = !active || (ZERO_REG && addr == '0);

        assign readData[p*XLEN +: XLEN] =
            zero ? '0 : (hit ? fwd : registers[addr]);

        // A bypassed operand is already available.
        assign readBusy[p] = !zero && !hit && busy[addr];
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_dbg
        assign debug_regs_flat[i*XLEN +: XLEN] = registers[i];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised scoreboard bench for regfile_mp (2R/2W, 32x32).
// Driver pushes model expectations; monitor pops at negedge.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NR   = 32;
    localparam int RP   = 2;
    localparam int WP   = 2;
    localparam int AW   = 5;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 ready;
    logic [RP*AW-1:0]     readAddress;
    logic [RP*XLEN-1:0]   readData;
    logic [RP-1:0]        readBusy;
    logic [WP-1:0]        writeEnable;
    logic [WP*AW-1:0]     writeAddress;
    logic [WP*XLEN-1:0]   writeData;
    logic                 reserveEnable;
    logic [AW-1:0]        reserveAddress;
    logic                 flush;
    logic [NR*XLEN-1:0]   debug_regs_flat;

    regfile_mp #(
        .XLEN(XLEN),
        .NUM_REGS(NR),
        .READ_PORTS(RP),
        .WRITE_PORTS(WP),
        .ZERO_REG(1'b1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ready(ready),
        .readAddress(readAddress),
        .readData(readData),
        .readBusy(readBusy),
        .writeEnable(writeEnable),
        .writeAddress(writeAddress),
        .writeData(writeData),
        .reserveEnable(reserveEnable),
        .reserveAddress(reserveAddress),
        .flush(flush),
        .debug_regs_flat(debug_regs_flat)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic        b0;
        logic        b1;
        logic        rdy;
        bit          dchk;
        int          didx;
        logic [31:0] dval;
    } exp_t;

    exp_t q[$];

    // Reference model: architectural contents, pending flags,
    // and the number of scrub cycles still outstanding.
    logic [31:0] mreg [NR];
    logic        mbusy [NR];
    int          scrub_left = 0;
    bit          known = 0;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t",
                     n, act, exp, $time);
        end
    endtask

    task automatic exp_read(input int a, output logic [31:0] d,
                            output logic b);
        bit hit;
        d = '0;
        b = 1'b0;
        hit = 0;
        if (!known || scrub_left != 0 || a == 0) return;
        for (int w = 0; w < WP; w++) begin
            if (writeEnable[w] &&
                int'(writeAddress[w*AW +: AW]) == a) begin
                hit = 1;
                d = writeData[w*XLEN +: XLEN];
            end
        end
        if (!hit) begin
            d = mreg[a];
            b = mbusy[a];
        end
    endtask

    task automatic step();
        exp_t e;
        int a;
        if (known) begin
            e.rdy = (scrub_left == 0);
            exp_read(int'(readAddress[4:0]), e.d0, e.b0);
            exp_read(int'(readAddress[9:5]), e.d1, e.b1);
            e.didx = int'($urandom_range(NR - 1));
            e.dchk = e.rdy;
            e.dval = mreg[e.didx];
            q.push_back(e);
        end
        if (reset) begin
            known = 1;
            scrub_left = NR;
            for (int i = 0; i < NR; i++) mbusy[i] = 1'b0;
        end else if (known) begin
            if (scrub_left > 0) begin
                scrub_left--;
                if (scrub_left == 0)
                    for (int i = 0; i < NR; i++) mreg[i] = '0;
            end else begin
                if (flush)
                    for (int i = 0; i < NR; i++) mbusy[i] = 1'b0;
                for (int w = 0; w < WP; w++) begin
                    a = int'(writeAddress[w*AW +: AW]);
                    if (writeEnable[w] && a != 0) begin
                        mreg[a]  = writeData[w*XLEN +: XLEN];
                        mbusy[a] = 1'b0;
                    end
                end
                if (reserveEnable && reserveAddress != '0)
                    mbusy[reserveAddress] = 1'b1;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        writeEnable    = '0;
        writeAddress   = '0;
        writeData      = '0;
        reserveEnable  = 1'b0;
        reserveAddress = '0;
        flush          = 1'b0;
        readAddress    = (RP*AW)'($urandom);
    endtask

    task automatic rnd();
        readAddress    = (RP*AW)'($urandom);
        writeEnable    = WP'($urandom);
        writeAddress   = (WP*AW)'($urandom);
        writeData      = {$urandom, $urandom};
        reserveEnable  = 1'($urandom);
        reserveAddress = AW'($urandom);
        flush          = ($urandom_range(15) == 0);
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        readAddress = {a1, a0};
    endtask

    task automatic wr0(input logic [4:0] a, input logic [31:0] d);
        writeEnable[0]    = 1'b1;
        writeAddress[4:0] = a;
        writeData[31:0]   = d;
    endtask

    task automatic wr1(input logic [4:0] a, input logic [31:0] d);
        writeEnable[1]     = 1'b1;
        writeAddress[9:5]  = a;
        writeData[63:32]   = d;
    endtask

    task automatic rsv(input logic [4:0] a);
        reserveEnable  = 1'b1;
        reserveAddress = a;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ready", 32'(ready), 32'(e.rdy));
                chk("rdata0", readData[31:0], e.d0);
                chk("rdata1", readData[63:32], e.d1);
                chk("rbusy0", 32'(readBusy[0]), 32'(e.b0));
                chk("rbusy1", 32'(readBusy[1]), 32'(e.b1));
                if (e.dchk)
                    chk($sformatf("debug_r%0d", e.didx),
                        debug_regs_flat[e.didx*XLEN +: XLEN],
                        e.dval);
            end
        end
    end

    initial begin : driver
        reset = 1'b1;
        idle();
        @(posedge clock);
        #1;

        // Power-up reset, then scrub with junk enables applied.
        repeat (3) step();
        reset = 1'b0;
        repeat (36) begin
            rnd();
            step();
        end

        // Fill with a pattern that the next scrub must wipe.
        for (int i = 0; i < NR; i++) begin
            idle();
            wr0(5'(i), 32'hDEADBEEF);
            step();
        end
        idle();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        repeat (10) step();
        // Restart mid-scrub.
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (33) begin
            idle();
            step();
        end
        for (int i = 0; i < NR / 2; i++) begin
            idle();
            rd(5'(2 * i), 5'(2 * i + 1));
            step();
        end

        // Bypass, storage and hardwired r0.
        idle(); rd(5'd0, 5'd5); wr0(5'd5, 32'h12345678); step();
        idle(); rd(5'd5, 5'd5); step();
        idle(); rd(5'd0, 5'd0); wr0(5'd0, 32'hFFFFFFFF); step();
        idle(); rd(5'd0, 5'd1); step();

        // Same-address dual write: port 1 wins.
        idle(); rd(5'd7, 5'd7);
        wr0(5'd7, 32'h0000AAAA); wr1(5'd7, 32'h00005555); step();
        idle(); rd(5'd7, 5'd6); step();

        // Scoreboard: reserve, write+reserve, lone write.
        idle(); rsv(5'd3); rd(5'd3, 5'd3); step();
        idle(); rd(5'd3, 5'd2); step();
        idle(); rsv(5'd3); wr0(5'd3, 32'h00000033);
        rd(5'd3, 5'd3); step();
        idle(); rd(5'd3, 5'd3); step();
        idle(); wr1(5'd3, 32'h00000077); rd(5'd3, 5'd0); step();
        idle(); rd(5'd3, 5'd3); step();

        // Flush coinciding with a new reservation.
        idle(); rsv(5'd1); step();
        idle(); rsv(5'd2); step();
        idle(); rsv(5'd4); step();
        idle(); flush = 1'b1; rsv(5'd9); rd(5'd1, 5'd9); step();
        idle(); rd(5'd1, 5'd2); step();
        idle(); rd(5'd4, 5'd9); step();
        idle(); rsv(5'd0); step();
        idle(); rd(5'd0, 5'd9); step();

        // Random traffic with occasional resets.
        repeat (3000) begin
            rnd();
            reset = ($urandom_range(299) == 0);
            step();
        end
        reset = 1'b0;
        idle();
        @(negedge clock);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
